// File: rtl/ssm_pkg.sv
// rtl/ssm_pkg.sv - shared types and arithmetic helpers for the SSM datapath
package ssm_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FINAL = 2'd2,
    S_OUT   = 2'd3
  } ga_state_e;

  // Headroom for MAX_TILES additions plus one spare bit for the xD add.
  function automatic int acc_width(input int dw, input int max_tiles);
    return dw + $clog2(max_tiles) + 1;
  endfunction

  // Sign-extend a DW-wide lane taken from a 64-bit container.
  function automatic logic signed [63:0] lane_sext(input logic [63:0] raw, input int dw);
    logic signed [63:0] v;
    v = $signed(raw << (64 - dw));
    return v >>> (64 - dw);
  endfunction

  // Returns {above_max, below_min} for a signed value clamped to dw bits.
  function automatic logic [1:0] sat_dir(input logic signed [63:0] v, input int dw);
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (dw - 1);
    return {v > (lim - 64'sd1), v < -lim};
  endfunction

endpackage

// File: rtl/ssm_sync_fifo.sv
// rtl/ssm_sync_fifo.sv - synchronous FIFO with registered full/empty flags
module ssm_sync_fifo #(
  parameter  int DW_F  = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  logic [DW_F-1:0] din,
  input  logic            pop,
  output logic [DW_F-1:0] dout,
  output logic            full,
  output logic            empty
);

  logic [AW:0]     wptr_q, rptr_q, wptr_d, rptr_d;
  logic [DW_F-1:0] mem [DEPTH];
  logic            full_q, empty_q, do_push, do_pop;

  // Push is gated by the registered full flag even when a pop happens alongside.
  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;
  assign wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
  assign rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
      empty_q <= (wptr_d == rptr_d);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem[rptr_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/ssm_group_accum.sv
// rtl/ssm_group_accum.sv - per-group tile accumulation, queued xD skip-add and saturation
module ssm_group_accum
  import ssm_pkg::*;
#(
  parameter  int DW        = 16,
  parameter  int H_TILE    = 1,
  parameter  int P_TILE    = 1,
  parameter  int MAX_TILES = 16,
  parameter  int XD_DEPTH  = 4,
  parameter  bit SAT_EN    = 1'b1,
  localparam int L         = H_TILE * P_TILE,
  localparam int CW        = $clog2(MAX_TILES + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [CW-1:0]   cfg_tiles_i,
  input  logic            xd_valid_i,
  output logic            xd_ready_o,
  input  logic [L*DW-1:0] xd_i,
  input  logic            tile_valid_i,
  output logic            tile_ready_o,
  input  logic [L*DW-1:0] tile_i,
  output logic            y_valid_o,
  input  logic            y_ready_i,
  output logic [L*DW-1:0] y_o,
  output logic            busy_o,
  output logic            sat_o
);

  localparam int ACC_W = acc_width(DW, MAX_TILES);
  localparam int SUM_W = ACC_W + 1;

  ga_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, t_q, t_eff;
  logic [L*ACC_W-1:0] acc_q, acc_next;
  logic [L*DW-1:0]  xd_q, fifo_dout, y_q, y_next;
  logic [L-1:0]     lane_hit;
  logic             y_valid_q, sat_q;
  logic             tile_acc, start, pop, y_take, fifo_empty, fifo_full;

  ssm_sync_fifo #(
    .DW_F  (L * DW),
    .DEPTH (XD_DEPTH)
  ) u_xd_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (xd_valid_i),
    .din   (xd_i),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    t_eff = cfg_tiles_i;
    if (cfg_tiles_i == '0)                   t_eff = CW'(1);
    else if (cfg_tiles_i > CW'(MAX_TILES))   t_eff = CW'(MAX_TILES);
  end

  // In OUT a new group may start in the same cycle the result is taken.
  always_comb begin
    tile_ready_o = 1'b0;
    case (state_q)
      S_IDLE, S_ACCUM: tile_ready_o = 1'b1;
      S_OUT:           tile_ready_o = y_valid_q & y_ready_i;
      default:         tile_ready_o = 1'b0;
    endcase
  end

  assign tile_acc = tile_valid_i & tile_ready_o;
  assign start    = tile_acc & ((state_q == S_IDLE) | (state_q == S_OUT));
  assign pop      = (state_q == S_FINAL) & ~fifo_empty;
  assign y_take   = y_valid_q & y_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tile_acc) state_d = (t_eff == CW'(1)) ? S_FINAL : S_ACCUM;
      S_ACCUM: if (tile_acc && (cnt_q + CW'(1) == t_q)) state_d = S_FINAL;
      S_FINAL: if (!fifo_empty) state_d = S_OUT;
      S_OUT: begin
        if (y_take) begin
          if (tile_acc) state_d = (t_eff == CW'(1)) ? S_FINAL : S_ACCUM;
          else          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar k = 0; k < L; k++) begin : g_lane
    logic [ACC_W-1:0] tile_sx, acc_l;
    logic [SUM_W-1:0] y_sum;
    logic [1:0]       dir;
    logic [DW-1:0]    sat_val;

    assign acc_l   = acc_q[ACC_W*k +: ACC_W];
    assign tile_sx = {{(ACC_W-DW){tile_i[DW*k+DW-1]}}, tile_i[DW*k +: DW]};
    assign acc_next[ACC_W*k +: ACC_W] = start ? tile_sx : acc_l + tile_sx;
    assign y_sum   = {acc_l[ACC_W-1], acc_l}
                   + {{(SUM_W-DW){xd_q[DW*k+DW-1]}}, xd_q[DW*k +: DW]};
    assign dir     = sat_dir({{(64-SUM_W){y_sum[SUM_W-1]}}, y_sum}, DW);
    assign sat_val = dir[1] ? {1'b0, {(DW-1){1'b1}}}
                   : dir[0] ? {1'b1, {(DW-1){1'b0}}}
                   : y_sum[DW-1:0];
    assign y_next[DW*k +: DW] = SAT_EN ? sat_val : y_sum[DW-1:0];
    assign lane_hit[k]        = SAT_EN & (|dir);
  end

  // xD is captured on the pop; the y register loads one cycle later in OUT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      t_q       <= '0;
      xd_q      <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (tile_acc) begin
        acc_q <= acc_next;
        cnt_q <= start ? CW'(1) : cnt_q + CW'(1);
        if (start) t_q <= t_eff;
      end
      if (pop) xd_q <= fifo_dout;
      if ((state_q == S_OUT) && !y_valid_q) begin
        y_q       <= y_next;
        y_valid_q <= 1'b1;
        sat_q     <= sat_q | (|lane_hit);
      end else if (y_take) begin
        y_valid_q <= 1'b0;
      end
    end
  end

  assign xd_ready_o = ~fifo_full;
  assign y_valid_o  = y_valid_q;
  assign y_o        = y_q;
  assign busy_o     = (state_q != S_IDLE);
  assign sat_o      = sat_q;

endmodule

// File: tb/tb_ssm_group_accum.sv
// tb/tb_ssm_group_accum.sv - scoreboard bench for ssm_group_accum (saturating and wrapping builds)
module tb_ssm_group_accum;

  localparam int DW = 16;
  localparam int VW = 32;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [CW-1:0] cfg;
  logic          xd_valid, tile_valid, y_ready;
  logic [VW-1:0] xd, tile;

  logic          xd_ready, tile_ready, y_valid, busy, sat;
  logic [VW-1:0] y;
  logic          w_xd_ready, w_tile_ready, w_y_valid, w_busy, w_sat;
  logic [VW-1:0] w_y;

  typedef struct {
    logic [VW-1:0] y;
    logic          sat;
  } exp_t;

  exp_t          q_sat[$];
  logic [VW-1:0] q_wrap[$];
  exp_t          e_m;
  logic [VW-1:0] e_w;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  ssm_group_accum #(
    .DW(DW), .H_TILE(1), .P_TILE(2), .MAX_TILES(16), .XD_DEPTH(4), .SAT_EN(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_tiles_i(cfg),
    .xd_valid_i(xd_valid), .xd_ready_o(xd_ready), .xd_i(xd),
    .tile_valid_i(tile_valid), .tile_ready_o(tile_ready), .tile_i(tile),
    .y_valid_o(y_valid), .y_ready_i(y_ready), .y_o(y),
    .busy_o(busy), .sat_o(sat)
  );

  ssm_group_accum #(
    .DW(DW), .H_TILE(1), .P_TILE(2), .MAX_TILES(16), .XD_DEPTH(4), .SAT_EN(1'b0)
  ) dut_wrap (
    .clk(clk), .rstn(rstn), .cfg_tiles_i(cfg),
    .xd_valid_i(xd_valid), .xd_ready_o(w_xd_ready), .xd_i(xd),
    .tile_valid_i(tile_valid), .tile_ready_o(w_tile_ready), .tile_i(tile),
    .y_valid_o(w_y_valid), .y_ready_i(y_ready), .y_o(w_y),
    .busy_o(w_busy), .sat_o(w_sat)
  );

  function automatic logic [VW-1:0] v2(input int l1, input int l0);
    logic [15:0] a, b;
    a = l1[15:0];
    b = l0[15:0];
    return {a, b};
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_y(input logic [VW-1:0] ys, input logic s, input logic [VW-1:0] yw);
    exp_t e;
    e.y = ys;
    e.sat = s;
    q_sat.push_back(e);
    q_wrap.push_back(yw);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tile(input logic [VW-1:0] t);
    logic rdy;
    int   n;
    n = 0;
    tile = t;
    tile_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = tile_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 300);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL tile_timeout: got tile_ready=0 expected 1 within 300 cycles");
    end
    tile_valid = 1'b0;
  endtask

  task automatic push_xd(input logic [VW-1:0] v);
    logic rdy;
    int   n;
    n = 0;
    xd = v;
    xd_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = xd_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 300);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL xd_timeout: got xd_ready=0 expected 1 within 300 cycles");
    end
    xd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_sat.size() != 0 || q_wrap.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q_sat.size() + q_wrap.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_y"}, y, '0);
    chk({tag, "_y_valid"}, y_valid, 0);
    chk({tag, "_sat"}, sat, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_xd_ready"}, xd_ready, 1);
    chk({tag, "_tile_ready"}, tile_ready, 1);
  endtask

  always @(negedge clk) begin
    if (rstn && y_valid && y_ready) begin
      checks++;
      if (q_sat.size() == 0) begin
        errors++;
        $display("FAIL y_unexpected: got y=%h with no result expected", y);
      end else begin
        e_m = q_sat.pop_front();
        if (y !== e_m.y || sat !== e_m.sat) begin
          errors++;
          $display("FAIL y_sat: got y=%h sat=%b expected y=%h sat=%b", y, sat, e_m.y, e_m.sat);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && w_y_valid && y_ready) begin
      checks++;
      if (q_wrap.size() == 0) begin
        errors++;
        $display("FAIL y_wrap_unexpected: got y=%h with no result expected", w_y);
      end else begin
        e_w = q_wrap.pop_front();
        if (w_y !== e_w || w_sat !== 1'b0) begin
          errors++;
          $display("FAIL y_wrap: got y=%h sat=%b expected y=%h sat=0", w_y, w_sat, e_w);
        end
      end
    end
  end

  initial begin
    cfg = 5'd4; xd_valid = 1'b0; xd = '0; tile_valid = 1'b0; tile = '0; y_ready = 1'b1;
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    sync();
    rstn = 1'b1;

    // Basic group, T = 4, then exact latency
    push_xd(v2(7, 10));
    cfg = 5'd4;
    expect_y(v2(2, 20), 1'b0, v2(2, 20));
    send_tile(v2(-5, 1)); send_tile(v2(0, 2)); send_tile(v2(0, 3)); send_tile(v2(0, 4));
    @(negedge clk); chk("lat_edge1", y_valid, 0); chk("busy_final", busy, 1);
    @(negedge clk); chk("lat_edge2", y_valid, 0);
    @(negedge clk); chk("lat_edge3", y_valid, 1);
    sync();

    // Saturation (wrap build must truncate instead)
    push_xd(v2(0, 0));
    cfg = 5'd2;
    expect_y(v2(16'h8000, 16'h7fff), 1'b1, v2(16'h2000, 16'he000));
    send_tile(v2(16'h9000, 16'h7000)); send_tile(v2(16'h9000, 16'h7000));

    // Tiles complete with the xD queue empty
    cfg = 5'd3;
    expect_y(v2(0, 604), 1'b1, v2(0, 604));
    send_tile(v2(-1, 100)); send_tile(v2(-2, 200)); send_tile(v2(-3, 300));
    repeat (5) @(negedge clk);
    chk("stall_valid", y_valid, 0); chk("stall_tile_ready", tile_ready, 0); chk("stall_busy", busy, 1);
    sync();
    push_xd(v2(6, 4));
    @(negedge clk); chk("stall_lat1", y_valid, 0);
    @(negedge clk); chk("stall_lat2", y_valid, 0);
    @(negedge clk); chk("stall_lat3", y_valid, 1);
    sync();

    // Fill the queue, then a fifth push must be refused
    push_xd(v2(2, 3)); push_xd(v2(0, -8)); push_xd(v2(16, 0)); push_xd(v2(0, 0));
    @(negedge clk); chk("xd_full", xd_ready, 0);
    xd = v2(99, 99); xd_valid = 1'b1;
    sync();
    @(negedge clk); chk("xd_full_5th", xd_ready, 0);
    sync();
    xd_valid = 1'b0;

    // Backpressure, then same-cycle handoff into a cfg = 0 group
    y_ready = 1'b0;
    cfg = 5'd2;
    expect_y(v2(3, 103), 1'b1, v2(3, 103));
    send_tile(v2(0, 50)); send_tile(v2(1, 50));
    begin
      int n;
      n = 0;
      while (!y_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp_wait_valid", y_valid, 1);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_y_hold", y, v2(3, 103));
      chk("bp_tile_ready", tile_ready, 0);
    end
    sync();
    cfg = 5'd0; tile = v2(9, 8); tile_valid = 1'b1; y_ready = 1'b1;
    expect_y(v2(9, 0), 1'b1, v2(9, 0));
    @(negedge clk); chk("bp_same_cycle_accept", tile_ready, 1);
    sync();
    tile_valid = 1'b0;
    @(negedge clk); chk("cfg0_final", tile_ready, 0);
    sync();

    // cfg above MAX_TILES clamps to 16
    cfg = 5'd31;
    expect_y(v2(0, 16), 1'b1, v2(0, 16));
    for (int i = 0; i < 16; i++) send_tile(v2(-1, 1));
    @(negedge clk); chk("cfg31_final", tile_ready, 0);
    sync();

    // cfg change mid-group is ignored until the next group
    cfg = 5'd3;
    expect_y(v2(-3000, 6000), 1'b1, v2(-3000, 6000));
    send_tile(v2(-1000, 1000));
    cfg = 5'd1;
    send_tile(v2(-1000, 2000));
    @(negedge clk); chk("mid_cfg_ready2", tile_ready, 1);
    sync();
    send_tile(v2(-1000, 3000));
    @(negedge clk); chk("mid_cfg_ready3", tile_ready, 0);
    drain();
    sync();

    // Asynchronous reset mid-group with xD queued
    push_xd(v2(5, 5)); push_xd(v2(6, 6));
    cfg = 5'd4;
    send_tile(v2(111, 111)); send_tile(v2(111, 111));
    #2 rstn = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    sync();
    rstn = 1'b1;
    cfg = 5'd2;
    expect_y(v2(26, 14), 1'b0, v2(26, 14));
    send_tile(v2(2, 1)); send_tile(v2(4, 3));
    repeat (3) @(negedge clk);
    chk("rst_queue_empty_valid", y_valid, 0);
    chk("rst_queue_empty_final", tile_ready, 0);
    sync();
    push_xd(v2(20, 10));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssm_group_accum.md
# ssm_group_accum

Group-reduction and skip-add stage for the SSM datapath, with full valid/ready handshaking on every port. It sits after the per-tile N-reduction and receives (h·p) partial sums, one vector per tile. It accumulates a runtime-configurable number of tiles per group, adds the matching x·D vector taken from an internal queue, saturates the result, and emits one (h·p) y vector per group. It replaces fixed-group accumulation that has no backpressure and a single xD latch: xD for several groups can now be queued ahead of the tile stream.

## Interface
- DW, 16: lane width, signed two's-complement fixed point.
- H_TILE, 1: heads per vector.
- P_TILE, 1: head-dim lanes per head. Lane count L = H_TILE·P_TILE.
- MAX_TILES, 16: maximum tiles per group.
- XD_DEPTH, 4: xD queue depth (power of 2, ≥2).
- SAT_EN, 1: 1 = saturate the final result to DW; 0 = wrap (truncate).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- cfg_tiles_i  in  $clog2(MAX_TILES+1)  tiles per group, sampled when a group's first tile is accepted.
- xd_valid_i  in  1  xD vector valid.
- xd_ready_o  out  1  = !xD queue full.
- xd_i  in  L·DW  x·D vector, lane k at [DW·(k+1)-1 -: DW].
- tile_valid_i  in  1  tile partial-sum valid.
- tile_ready_o  out  1  tile accept.
- tile_i  in  L·DW  per-tile (h·p) partial sum.
- y_valid_o  out  1  result valid.
- y_ready_i  in  1  downstream accept.
- y_o  out  L·DW  final y vector.
- busy_o  out  1  state ≠ IDLE.
- sat_o  out  1  sticky flag: some lane saturated since reset.

## Operation
- Accumulator: L lanes, each ACC_W = DW + $clog2(MAX_TILES) + 1 bits. Tile lanes are sign-extended before adding. Intermediate sums never overflow.
- Effective tile count T = clamp(cfg_tiles_i, 1, MAX_TILES). A value of 0 is treated as 1.
- FSM states: IDLE, ACCUM, FINAL, OUT.
  - IDLE: tile_ready_o = 1. On accept: acc ← tile, cnt ← 1, latch T. Go to FINAL if T == 1, else ACCUM.
  - ACCUM: tile_ready_o = 1. On accept: acc ← acc + tile, cnt++. Go to FINAL when the accepted tile makes cnt == T.
  - FINAL: tile_ready_o = 0. If the xD queue is non-empty: pop it, y_o ← sat(acc + sext(xD)) per lane, go to OUT. If the queue is empty, stall in FINAL.
  - OUT: y_valid_o = 1, y_o held stable. tile_ready_o = y_ready_i, so a new group's first tile can be accepted in the same cycle the result is taken.
    - On y_ready_i & tile_valid_i: start the new group exactly as in IDLE.
    - On y_ready_i only: go to IDLE.
- Saturation (SAT_EN = 1): each lane is clamped to [-2^(DW-1), 2^(DW-1)-1]. Any lane clamping sets sat_o. With SAT_EN = 0, the low DW bits are kept and sat_o stays 0.
- xD queue:
  - A push is accepted when xd_valid_i & xd_ready_o; xd_ready_o is derived from the registered full flag.
  - Pushing and popping in the same cycle is legal when the queue is neither full nor empty.
  - When full, a push is not accepted even if a pop happens the same cycle.
  - Order is FIFO: the k-th pushed xD pairs with the k-th group.
- Reset (asynchronous, also mid-group):
  - state = IDLE, acc = 0, cnt = 0, xD queue empty.
  - Outputs: y_o = 0, y_valid_o = 0, sat_o = 0, busy_o = 0, xd_ready_o = 1, tile_ready_o = 1.

## Timing
- One tile accepted per cycle in IDLE/ACCUM.
- Latency: y_valid_o rises on the 2nd rising edge after the edge that accepts the group's last tile, provided xD is queued. Each cycle the queue is empty in FINAL adds one cycle.
- Throughput with continuous streaming and y_ready_i = 1: one group every T+2 cycles.
- y_o and y_valid_o are registered. They hold while y_valid_o & !y_ready_i.
- cfg_tiles_i changes mid-group have no effect until the next group's first accept.

## Structure
- Shared package ssm_pkg: lane extract/insert function, ACC_W computation, signed saturate function.
- Sub-module ssm_sync_fifo (DW_F = L·DW, DEPTH = XD_DEPTH):
  - Registered full/empty flags.
  - Pointers one bit wider than the address.
  - Reused elsewhere in the SSM pipeline.
- Remainder (FSM, accumulator, saturation): roughly 200 lines in ssm_group_accum.

## Test plan
- Basic: L = 2, T = 4. Tiles lane0 = {1, 2, 3, 4}, lane1 = {-5, 0, 0, 0}; xD = {10, 7}. Required: y = {20, 2} and y_valid_o exactly 2 edges after the 4th tile is accepted.
- Saturation: DW = 16, T = 2, tiles 0x7000 + 0x7000, xD = 0. Required: y = 0x7FFF, sat_o = 1. Repeat with SAT_EN = 0: y = 0xE000, sat_o = 0.
- xD stall and queueing:
  - Tiles arrive with the queue empty: FSM holds in FINAL. Push xD 5 cycles later; y appears 1 cycle after the pop.
  - Push 4 xD with XD_DEPTH = 4: xd_ready_o = 0 on the 5th attempt.
- Backpressure: hold y_ready_i = 0 for 6 cycles. Required: y_o stable, tile_ready_o = 0. Then raise y_ready_i with tile_valid_i = 1: the next group's first tile is accepted in that same cycle.
- Config edges:
  - cfg_tiles_i = 0 behaves as T = 1.
  - cfg_tiles_i = 31 with MAX_TILES = 16 behaves as T = 16.
  - Changing cfg_tiles_i mid-group does not alter the current group.
- Reset mid-group: assert rstn low after 2 of 4 tiles with 2 xD queued. Required: all outputs at reset values, queue empty. The next group's result excludes the prior tiles.
